// File: rtl/dm_lsu_pkg.sv
// dm_lsu shared types and constants.
// Op codes, FSM states and byte-enable patterns.
package dm_lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/dm_lsu_lane.sv
// Lane steering for dm_lsu: byte enables, store replication,
// load extraction and op/alignment checks.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] dout,
  output logic [3:0]  be,
  output logic [31:0] din,
  output logic [31:0] rdata,
  output logic        misal,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = dout >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = off[1] ? dout[31:16] : dout[15:0];

  // Decode size/sign and steer data lanes.
  always_comb begin
    be      = BE_NONE;
    din     = wdata;
    rdata   = dout;
    misal   = 1'b0;
    illegal = 1'b0;
    unique case (op)
      OP_B, OP_BU: begin
        be      = BE_B0 << off;
        din     = {4{wdata[7:0]}};
        rdata   = op[2] ? {24'h0, byte_v}
                        : {{24{byte_v[7]}}, byte_v};
        illegal = op[2] & we;
      end
      OP_H, OP_HU: begin
        be      = off[1] ? BE_HHI : BE_HLO;
        din     = {2{wdata[15:0]}};
        rdata   = op[2] ? {16'h0, half_v}
                        : {{16{half_v[15]}}, half_v};
        misal   = off[0];
        illegal = op[2] & we;
      end
      OP_W: begin
        be    = BE_ALL;
        misal = |off;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator between execute stage and data memory.
// Three-state FSM: IDLE -> ACCESS -> RESP, errors skip ACCESS.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int AW_HI = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [AW_HI-2:0]  dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  state_t      state, nxt;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        idle;
  logic        accept;
  logic        oor;
  logic        req_err;
  logic [2:0]  l_op;
  logic [1:0]  l_off;
  logic        l_we;
  logic [3:0]  l_be;
  logic [31:0] l_din;
  logic [31:0] l_rdata;
  logic        l_misal;
  logic        l_illegal;

  assign idle    = (state == ST_IDLE);
  assign accept  = idle & req_valid;
  assign oor     = |req_addr[31:AW_HI+1];
  assign req_err = l_misal | l_illegal | oor;

  // Lane logic sees the live request in IDLE, the captured one after.
  assign l_op  = idle ? req_op : op_q;
  assign l_off = idle ? req_addr[1:0] : off_q;
  assign l_we  = idle ? req_we : we_q;

  dm_lsu_lane u_lane (
    .op      (l_op),
    .off     (l_off),
    .we      (l_we),
    .wdata   (req_wdata),
    .dout    (dm_dout),
    .be      (l_be),
    .din     (l_din),
    .rdata   (l_rdata),
    .misal   (l_misal),
    .illegal (l_illegal)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state and handshake/memory strobes.
  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dm_we      = 1'b0;
    dm_be      = BE_NONE;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_we = we_q;
        dm_be = l_be;
        nxt   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Request capture, memory address/data and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      op_q       <= OP_B;
      off_q      <= 2'b00;
      dm_addr    <= '0;
      dm_din     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      op_q       <= req_op;
      off_q      <= req_addr[1:0];
      resp_err   <= req_err;
      resp_rdata <= '0;
      if (!req_err) begin
        dm_addr <= req_addr[AW_HI:2];
        dm_din  <= l_din;
      end
    end else if (state == ST_ACCESS) begin
      resp_rdata <= we_q ? 32'h0 : l_rdata;
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed self-checking bench for dm_lsu.
// Behavioural word memory with byte enables stands in for dm.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  localparam int AW_HI = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_op = 3'b000;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [AW_HI-2:0]  dm_addr;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;

  logic [31:0] mem [128] = '{default: 32'h0};

  int total  = 0;
  int passed = 0;

  logic [31:0]      r_rdata;
  logic             r_err;
  int               r_lat;
  logic             a_we;
  logic [3:0]       a_be;
  logic [AW_HI-2:0] a_addr;
  logic [31:0]      a_din;
  logic             we_seen;

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we)
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
  end

  dm_lsu #(.AW_HI(AW_HI)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (dm_dout)
  );

  // One full transaction; records the cycle after accept and the response.
  task automatic xact(input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    a_we    = dm_we;
    a_be    = dm_be;
    a_addr  = dm_addr;
    a_din   = dm_din;
    we_seen = dm_we;
    r_lat   = 1;
    while (!resp_valid && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
      we_seen |= dm_we;
    end
    r_rdata = resp_rdata;
    r_err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({resp_valid, resp_err, dm_we, dm_be, dm_addr, dm_din, resp_rdata}
        !== '0)
      $display("FAIL reset_outputs: got v=%b e=%b we=%b be=%b a=%h d=%h r=%h want all 0",
               resp_valid, resp_err, dm_we, dm_be, dm_addr, dm_din, resp_rdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL reset_ready: got ready=%b valid=%b want 1 0",
               req_ready, resp_valid);
    else passed++;
  endtask

  task automatic test_word;
    xact(1'b1, OP_W, 32'h10, 32'hDEADBEEF);
    total++;
    if ({a_we, a_be} !== 5'b11111 || a_addr !== 7'd4 ||
        a_din !== 32'hDEADBEEF)
      $display("FAIL sw_access: got we=%b be=%b a=%h d=%h want 1 1111 04 deadbeef",
               a_we, a_be, a_addr, a_din);
    else passed++;
    total++;
    if (r_err !== 1'b0 || r_rdata !== 32'h0 || r_lat != 2)
      $display("FAIL sw_resp: got err=%b r=%h lat=%0d want 0 0 2",
               r_err, r_rdata, r_lat);
    else passed++;
    xact(1'b0, OP_W, 32'h10, 32'h0);
    total++;
    if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0 || r_lat != 2 ||
        we_seen !== 1'b0)
      $display("FAIL lw_resp: got r=%h err=%b lat=%0d we=%b want deadbeef 0 2 0",
               r_rdata, r_err, r_lat, we_seen);
    else passed++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = OP_W;
    req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_op    = OP_W;
    req_addr  = 32'h40;
    req_wdata = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF ||
          req_ready !== 1'b0 || dm_we !== 1'b0)
        $display("FAIL hold_%0d: got v=%b r=%h rdy=%b we=%b want 1 deadbeef 0 0",
                 i, resp_valid, resp_rdata, req_ready, dm_we);
      else passed++;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL hold_release: got v=%b rdy=%b want 0 1",
               resp_valid, req_ready);
    else passed++;
    xact(1'b0, OP_W, 32'h40, 32'h0);
    total++;
    if (r_rdata !== 32'h0)
      $display("FAIL hold_nocapture: got %h want 00000000", r_rdata);
    else passed++;
  endtask

  task automatic test_byte;
    xact(1'b1, OP_B, 32'h13, 32'h000000F0);
    total++;
    if (a_be !== 4'b1000 || a_din !== 32'hF0F0F0F0 || a_we !== 1'b1)
      $display("FAIL sb_access: got be=%b d=%h we=%b want 1000 f0f0f0f0 1",
               a_be, a_din, a_we);
    else passed++;
    xact(1'b0, OP_B, 32'h13, 32'h0);
    total++;
    if (r_rdata !== 32'hFFFFFFF0 || a_be !== 4'b1000)
      $display("FAIL lb: got r=%h be=%b want fffffff0 1000", r_rdata, a_be);
    else passed++;
    xact(1'b0, OP_BU, 32'h13, 32'h0);
    total++;
    if (r_rdata !== 32'h000000F0)
      $display("FAIL lbu: got %h want 000000f0", r_rdata);
    else passed++;
    xact(1'b0, OP_W, 32'h10, 32'h0);
    total++;
    if (r_rdata !== 32'hF0ADBEEF)
      $display("FAIL sb_merge: got %h want f0adbeef", r_rdata);
    else passed++;
  endtask

  task automatic test_half;
    xact(1'b1, OP_H, 32'h22, 32'h12348001);
    total++;
    if (a_be !== 4'b1100 || a_din !== 32'h80018001 || a_addr !== 7'd8)
      $display("FAIL sh_access: got be=%b d=%h a=%h want 1100 80018001 08",
               a_be, a_din, a_addr);
    else passed++;
    xact(1'b0, OP_H, 32'h22, 32'h0);
    total++;
    if (r_rdata !== 32'hFFFF8001)
      $display("FAIL lh: got %h want ffff8001", r_rdata);
    else passed++;
    xact(1'b0, OP_HU, 32'h22, 32'h0);
    total++;
    if (r_rdata !== 32'h00008001)
      $display("FAIL lhu: got %h want 00008001", r_rdata);
    else passed++;
  endtask

  task automatic test_errors;
    logic [31:0] ea [4];
    logic [2:0]  eo [4];
    logic        ew [4];
    logic [31:0] chk [3];
    ea = '{32'h06, 32'h41, 32'h200, 32'h44};
    eo = '{OP_W, OP_H, OP_W, OP_HU};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      xact(ew[i], eo[i], ea[i], 32'h5A5A5A5A);
      total++;
      if (r_err !== 1'b1 || r_lat != 1 || we_seen !== 1'b0 ||
          r_rdata !== 32'h0)
        $display("FAIL err_%0d: got err=%b lat=%0d we=%b r=%h want 1 1 0 0",
                 i, r_err, r_lat, we_seen, r_rdata);
      else passed++;
    end
    chk = '{32'h40, 32'h00, 32'h44};
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, OP_W, chk[i], 32'h0);
      total++;
      if (r_rdata !== 32'h0)
        $display("FAIL err_mem_%0d: got %h want 00000000", i, r_rdata);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    xact(1'b1, OP_W, 32'h30, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_op    = OP_W;
    req_addr  = 32'h30;
    req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (dm_we !== 1'b1)
      $display("FAIL rst_mid_access: got we=%b want 1", dm_we);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rst_mid_state: got v=%b rdy=%b want 0 1",
               resp_valid, req_ready);
    else passed++;
    xact(1'b0, OP_W, 32'h30, 32'h0);
    total++;
    if (r_rdata !== 32'h11223344)
      $display("FAIL rst_mid_mem: got %h want 11223344", r_rdata);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_word;
    test_backpressure;
    test_byte;
    test_half;
    test_errors;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
